// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the ALU writeback path (A, priority)
// and the load/multi-cycle writeback path (B, starvation-protected). The write is registered.
module regfile_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              AValid,
    input  logic [ADDR_W-1:0] AReg,
    input  logic [DATA_W-1:0] AData,
    output logic              AReady,
    input  logic              BValid,
    input  logic [ADDR_W-1:0] BReg,
    input  logic [DATA_W-1:0] BData,
    output logic              BReady,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic [3:0]        StarveCnt
);

    logic aReal;
    logic bReal;
    logic grantA;
    logic grantB;
    logic bForce;

    assign bForce = (StarveCnt >= 4'(STARVE_LIMIT));

    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        aReal  = AValid && (AReg != '0);
        bReal  = BValid && (BReg != '0);
        grantB = bReal && (!aReal || bForce);
        grantA = aReal && !grantB;
        // Register-0 writes are sunk without occupying the port.
        AReady = Reset_n && AValid && (!aReal || grantA);
        BReady = Reset_n && BValid && (!bReal || grantB);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            StarveCnt <= 4'd0;
        end else if (!BValid || BReady) begin
            StarveCnt <= 4'd0;
        end else if (bReal && !grantB && (StarveCnt != 4'd15)) begin
            StarveCnt <= StarveCnt + 4'd1;
        end
    end

    // NOTE: address/data are reset too, so an aborted write leaves a clean, known output.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= grantA || grantB;
            if (grantB) begin
                WriteRegister <= BReg;
                WriteData     <= BData;
            end else if (grantA) begin
                WriteRegister <= AReg;
                WriteData     <= AData;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a small register-file model fed by the write port.
module tb_regfile_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              AValid;
    logic [ADDR_W-1:0] AReg;
    logic [DATA_W-1:0] AData;
    logic              AReady;
    logic              BValid;
    logic [ADDR_W-1:0] BReg;
    logic [DATA_W-1:0] BData;
    logic              BReady;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;
    logic [3:0]        StarveCnt;

    int assertCount = 0;
    int failCount   = 0;

    logic [DATA_W-1:0] regFile [32];

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(3)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .AValid(AValid), .AReg(AReg), .AData(AData), .AReady(AReady),
        .BValid(BValid), .BReg(BReg), .BData(BData), .BReady(BReady),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .StarveCnt(StarveCnt)
    );

    always #5 Clk = ~Clk;

    initial for (int i = 0; i < 32; i++) regFile[i] = '0;

    always @(posedge Clk) begin
        if (RegWrite) regFile[WriteRegister] <= WriteData;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n = 1'b0;
        AValid = 1'b1; AReg = 5'd5; AData = 32'h1111_1111;
        BValid = 1'b0; BReg = '0;   BData = '0;
        #3;
        check("rst_regwrite", RegWrite, 0);
        check("rst_wreg", WriteRegister, 0);
        check("rst_wdata", WriteData, 0);
        check("rst_starve", StarveCnt, 0);
        check("rst_aready", AReady, 0);

        // Release with A pending
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        check("rel_aready", AReady, 1);
        tick();
        check("rel_regwrite", RegWrite, 1);
        check("rel_wreg", WriteRegister, 5);
        check("rel_wdata", WriteData, 32'h1111_1111);
        AValid = 1'b0;
        tick();
        check("rel_idle_regwrite", RegWrite, 0);
        check("rel_idle_hold_wreg", WriteRegister, 5);

        // Both contending: A,A,A,B repeating
        AValid = 1'b1; AReg = 5'd3; AData = 32'h33;
        BValid = 1'b1; BReg = 5'd4; BData = 32'h44;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("arb_cnt_pre%0d", i), StarveCnt, i % 4);
            check($sformatf("arb_aready%0d", i), AReady, (i % 4) != 3);
            check($sformatf("arb_bready%0d", i), BReady, (i % 4) == 3);
            tick();
            check($sformatf("arb_regwrite%0d", i), RegWrite, 1);
            check($sformatf("arb_wreg%0d", i), WriteRegister, ((i % 4) == 3) ? 4 : 3);
            check($sformatf("arb_cnt_post%0d", i), StarveCnt, ((i % 4) == 3) ? 0 : (i % 4) + 1);
        end

        // Register-0 sink lets B through in the same cycle
        AReg = 5'd0; AData = 32'hDEAD_BEEF;
        BReg = 5'd7; BData = 32'h22;
        #1;
        check("zero_aready", AReady, 1);
        check("zero_bready", BReady, 1);
        tick();
        check("zero_regwrite", RegWrite, 1);
        check("zero_wreg", WriteRegister, 7);
        check("zero_wdata", WriteData, 32'h22);

        // Same destination: A first, B overwrites
        AReg = 5'd9; AData = 32'hA;
        BReg = 5'd9; BData = 32'hB;
        #1;
        check("same_cnt0", StarveCnt, 0);
        check("same_aready", AReady, 1);
        check("same_bready_lose", BReady, 0);
        tick();
        check("same_first_wdata", WriteData, 32'hA);
        AValid = 1'b0;
        #1;
        check("same_bready_win", BReady, 1);
        tick();
        check("same_second_wdata", WriteData, 32'hB);
        check("same_second_wreg", WriteRegister, 9);
        BValid = 1'b0;
        tick();
        check("same_rf9", regFile[9], 32'hB);
        check("same_idle_regwrite", RegWrite, 0);

        // Asynchronous reset mid-cycle while RegWrite is high
        AValid = 1'b1; AReg = 5'd12; AData = 32'h55;
        BValid = 1'b1; BReg = 5'd13; BData = 32'h66;
        tick();
        check("arst_pre_regwrite", RegWrite, 1);
        check("arst_pre_cnt", StarveCnt, 1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("arst_regwrite", RegWrite, 0);
        check("arst_wreg", WriteRegister, 0);
        check("arst_wdata", WriteData, 0);
        check("arst_cnt", StarveCnt, 0);
        check("arst_aready", AReady, 0);
        check("arst_bready", BReady, 0);
        tick();
        check("arst_held_regwrite", RegWrite, 0);
        check("arst_held_aready", AReady, 0);
        AValid = 1'b0; BValid = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
        check("arst_rel_regwrite", RegWrite, 0);

        // B alone to reg 31, back to back
        BValid = 1'b1; BReg = 5'd31;
        for (int i = 0; i < 5; i++) begin
            BData = 32'h100 + i;
            #1;
            check($sformatf("bonly_bready%0d", i), BReady, 1);
            tick();
            check($sformatf("bonly_regwrite%0d", i), RegWrite, 1);
            check($sformatf("bonly_wdata%0d", i), WriteData, 32'h100 + i);
            check($sformatf("bonly_cnt%0d", i), StarveCnt, 0);
        end
        BValid = 1'b0;
        tick();
        tick();
        check("rf31_final", regFile[31], 32'h104);
        check("rf0_never", regFile[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
